ttt_move_engine: RTL and testbench
==================================

TTT_MOVE_ENGINE -- requirements
Module: ttt_move_engine

Interface
REQ-001 SHALL have the following ports, clock and reset first; Clk and Resetn are sampled as described.
- Clk  in  1  — single system clock; all state changes on its rising edge.
- Resetn  in  1  — asynchronous, active-low reset.
- Clear  in  1  — synchronous board/flag clear, issued by the game controller at game start.
- MoveReq  in  1  — level request for one move, four-phase handshake.
- Player  in  1  — mover identity: 0 = X, 1 = O.
- BtnU, BtnD, BtnL, BtnR, BtnC  in  1 each  — debounced single-cycle button pulses.
- MoveAck  out  1  — one-cycle pulse when a move is committed and evaluated.
- Invalid  out  1  — one-cycle pulse when BtnC lands on an occupied cell.
- Xwins, Owins, Draw  out  1 each  — game result flags, sticky.
- CurX, CurY  out  2 each  — cursor column and row, range 0..2.
- Cells  out  18  — board contents, 2 bits per cell, index = 3*row+col at bits [2i+1:2i]; 00 empty, 01 X, 10 O.
- MoveCnt  out  4  — number of committed moves, 0..9.

Function
REQ-002 SHALL implement the FSM states IDLE, WAIT, COMMIT, EVAL, ACK and RELEASE, encoded one-hot.
REQ-003 IDLE -> WAIT SHALL occur when MoveReq=1 and Xwins|Owins|Draw=0; Player SHALL be latched on this transition.
REQ-004 When a game result is already set, IDLE SHALL ignore MoveReq and issue no MoveAck.
REQ-005 In WAIT, button priority SHALL be C > U > D > L > R, with only one action taken per cycle.
REQ-006 Cursor moves in WAIT SHALL wrap: U from row 0 -> 2, D from row 2 -> 0, L from col 0 -> 2, R from col 2 -> 0. Buttons outside WAIT SHALL be ignored.
REQ-007 On BtnC in WAIT:
- selected cell empty -> go to COMMIT;
- selected cell occupied -> pulse Invalid for 1 cycle and stay in WAIT.
REQ-008 COMMIT SHALL write the latched Player code into the cell at (CurY, CurX) and increment MoveCnt; the next state SHALL be EVAL.
REQ-009 EVAL SHALL check all 8 lines (3 rows, 3 columns, 2 diagonals) for three equal non-empty codes:
- X line -> Xwins=1;
- O line -> Owins=1;
- no line and MoveCnt==9 -> Draw=1.
A win SHALL take precedence over Draw on the 9th move. Next state SHALL be ACK.
REQ-010 ACK SHALL assert MoveAck for exactly 1 cycle, with the updated flags already visible in that cycle; next state SHALL be RELEASE.
REQ-011 RELEASE SHALL hold until MoveReq=0, then go to IDLE; one request SHALL yield at most one move.
REQ-012 Latency from an accepted BtnC (in WAIT) to MoveAck high SHALL be exactly 3 cycles.
REQ-013 If MoveReq drops while in WAIT, the FSM SHALL return to IDLE with no write and no ack.
REQ-014 If MoveReq drops in COMMIT, EVAL or ACK, the move SHALL still complete.
REQ-015 Clear=1 in any state SHALL, at the next edge:
- set all Cells to 00;
- set MoveCnt=0;
- set Xwins=Owins=Draw=0;
- set the cursor to (1,1);
- set the FSM to IDLE.
Clear SHALL override all other inputs in that cycle.
REQ-016 Result flags SHALL change only in EVAL, on Clear, or on reset.
REQ-017 MoveCnt SHALL never exceed 9; a write SHALL only ever target an empty cell.

Reset
REQ-018 Resetn=0 SHALL asynchronously force:
- FSM to IDLE;
- Cells=0, MoveCnt=0;
- Xwins=Owins=Draw=0;
- MoveAck=Invalid=0;
- CurX=CurY=1.
REQ-019 Resetn asserted mid-move SHALL abort the move with no partial write; after release, operation SHALL resume from IDLE on the first rising Clk edge with Resetn=1.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset, then MoveReq=1, Player=0, BtnC -> Cells[9:8]=01, MoveCnt=1, MoveAck 3 cycles after BtnC, no flags set.
- Cursor wrap: from (1,1) press BtnR twice, then BtnU twice -> CurX=0, CurY=2.
- BtnC on an occupied cell -> Invalid pulse for 1 cycle, Cells unchanged, no MoveAck, FSM stays in WAIT.
- X plays cells 0, 1, 2 interleaved with O on 3, 4 -> Xwins=1 in the MoveAck cycle of move 5, and the next MoveReq is ignored.
- Nine moves with no line -> Draw=1, MoveCnt=9; the 9th move completing a line -> win flag set and Draw=0.
- BtnC and BtnU in the same cycle -> commit at the original cursor position; Clear asserted in EVAL -> board empty, IDLE, no MoveAck; Resetn pulsed while in COMMIT -> all outputs at reset values.

Source files
------------

// File: rtl/ttt_move_engine.sv
// Tic-tac-toe move engine: the requesting player steers a cursor over the
// 3x3 board with button pulses and commits a mark. The engine then checks
// all eight lines and reports the game result with a single MoveAck pulse.
module ttt_move_engine (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Clear,
    input  logic        MoveReq,
    input  logic        Player,
    input  logic        BtnU,
    input  logic        BtnD,
    input  logic        BtnL,
    input  logic        BtnR,
    input  logic        BtnC,
    output logic        MoveAck,
    output logic        Invalid,
    output logic        Xwins,
    output logic        Owins,
    output logic        Draw,
    output logic [1:0]  CurX,
    output logic [1:0]  CurY,
    output logic [17:0] Cells,
    output logic [3:0]  MoveCnt
);

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        WAIT    = 6'b000010,
        COMMIT  = 6'b000100,
        EVAL    = 6'b001000,
        ACK     = 6'b010000,
        RELEASE = 6'b100000
    } state_t;

    localparam logic [1:0] CODE_X = 2'b01;
    localparam logic [1:0] CODE_O = 2'b10;

    state_t      state, state_nxt;
    logic        player_q;
    logic [3:0]  sel;
    logic [1:0]  sel_cell;
    logic        sel_empty;
    logic        result_set;
    logic        x_line, o_line;

    function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c, input logic [1:0] code);
        return (a == code) && (b == code) && (c == code);
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] code);
        logic [1:0] c [9];
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        return line3(c[0], c[1], c[2], code) | line3(c[3], c[4], c[5], code) |
               line3(c[6], c[7], c[8], code) | line3(c[0], c[3], c[6], code) |
               line3(c[1], c[4], c[7], code) | line3(c[2], c[5], c[8], code) |
               line3(c[0], c[4], c[8], code) | line3(c[2], c[4], c[6], code);
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    // Cell under the cursor and board-wide line detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_cell = 2'b00;
        sel      = {2'b00, CurY} * 4'd3 + {2'b00, CurX};
        for (int i = 0; i < 9; i++) begin
            if (sel == 4'(i)) sel_cell = Cells[2*i +: 2];
        end
        sel_empty  = (sel_cell == 2'b00);
        result_set = Xwins | Owins | Draw;
        x_line     = has_line(Cells, CODE_X);
        o_line     = has_line(Cells, CODE_O);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Resetn) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; Clear wins over everything else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MoveReq && !result_set) state_nxt = WAIT;
            WAIT: begin
                if (!MoveReq)                state_nxt = IDLE;
                else if (BtnC && sel_empty)  state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = EVAL;
            EVAL:    state_nxt = ACK;
            ACK:     state_nxt = RELEASE;
            RELEASE: if (!MoveReq) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Clear) state_nxt = IDLE;
    end

    assign MoveAck = (state == ACK);

    // Board, cursor, move counter, result flags and the Invalid pulse.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: the board is a small flop array, not a RAM, so it is reset with the rest.
            Cells    <= '0;
            MoveCnt  <= '0;
            Xwins    <= 1'b0;
            Owins    <= 1'b0;
            Draw     <= 1'b0;
            Invalid  <= 1'b0;
            CurX     <= 2'd1;
            CurY     <= 2'd1;
            player_q <= 1'b0;
        end else if (Clear) begin
            Cells    <= '0;
            MoveCnt  <= '0;
            Xwins    <= 1'b0;
            Owins    <= 1'b0;
            Draw     <= 1'b0;
            Invalid  <= 1'b0;
            CurX     <= 2'd1;
            CurY     <= 2'd1;
        end else begin
            Invalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (MoveReq && !result_set) player_q <= Player;
                end
                WAIT: begin
                    if (MoveReq) begin
                        if (BtnC) begin
                            if (!sel_empty) Invalid <= 1'b1;
                        end
                        else if (BtnU) CurY <= wrap_dec(CurY);
                        else if (BtnD) CurY <= wrap_inc(CurY);
                        else if (BtnL) CurX <= wrap_dec(CurX);
                        else if (BtnR) CurX <= wrap_inc(CurX);
                    end
                end
                COMMIT: begin
                    // Guard keeps the count bounded and never overwrites a mark.
                    if (sel_empty && (MoveCnt < 4'd9)) begin
                        for (int i = 0; i < 9; i++) begin
                            if (sel == 4'(i)) Cells[2*i +: 2] <= player_q ? CODE_O : CODE_X;
                        end
                        MoveCnt <= MoveCnt + 4'd1;
                    end
                end
                EVAL: begin
                    if (x_line) Xwins <= 1'b1;
                    if (o_line) Owins <= 1'b1;
                    if (!x_line && !o_line && (MoveCnt == 4'd9)) Draw <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_move_engine.sv
// Directed bench for ttt_move_engine: table-driven games plus hand-written
// sequences for invalid presses, cursor wrap, Clear in EVAL and reset mid-move.
module tb_ttt_move_engine;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        Clear = 1'b0, MoveReq = 1'b0, Player = 1'b0;
    logic        BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
    logic        MoveAck, Invalid, Xwins, Owins, Draw;
    logic [1:0]  CurX, CurY;
    logic [17:0] Cells;
    logic [3:0]  MoveCnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cx = 1, cy = 1;   // bench model of the cursor

    typedef struct {
        logic        p;
        int          col;
        int          row;
        logic [17:0] cells;
        logic [3:0]  cnt;
        logic        xw;
        logic        ow;
        logic        dr;
    } move_t;

    move_t game_x[$];
    move_t game_draw[$];
    move_t game_late[$];

    ttt_move_engine dut (
        .Clk(Clk), .Resetn(Resetn), .Clear(Clear), .MoveReq(MoveReq), .Player(Player),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
        .MoveAck(MoveAck), .Invalid(Invalid), .Xwins(Xwins), .Owins(Owins), .Draw(Draw),
        .CurX(CurX), .CurY(CurY), .Cells(Cells), .MoveCnt(MoveCnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        cx = 1;
        cy = 1;
    endtask

    // One complete move: request, steer, commit, wait for ack, release.
    task automatic play(input move_t m, input string tag);
        int lat;
        MoveReq = 1'b1;
        Player  = m.p;
        tick();
        repeat ((m.col - cx + 3) % 3) begin BtnR = 1'b1; tick(); BtnR = 1'b0; end
        repeat ((m.row - cy + 3) % 3) begin BtnD = 1'b1; tick(); BtnD = 1'b0; end
        cx = m.col;
        cy = m.row;
        BtnC = 1'b1;
        lat  = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            BtnC = 1'b0;
            if (MoveAck) begin lat = k; break; end
        end
        check({tag, " ack latency"}, lat, 3);
        check({tag, " cells"}, Cells, m.cells);
        check({tag, " movecnt"}, MoveCnt, m.cnt);
        check({tag, " flags at ack"}, {Xwins, Owins, Draw}, {m.xw, m.ow, m.dr});
        MoveReq = 1'b0;
        tick();
        check({tag, " ack one cycle"}, MoveAck, 1'b0);
        tick();
    endtask

    initial begin
        int acks;

        // X wins on row 0 at move 5.
        game_x.push_back('{1'b0, 0, 0, 18'h00001, 4'd1, 1'b0, 1'b0, 1'b0});
        game_x.push_back('{1'b1, 0, 1, 18'h00081, 4'd2, 1'b0, 1'b0, 1'b0});
        game_x.push_back('{1'b0, 1, 0, 18'h00085, 4'd3, 1'b0, 1'b0, 1'b0});
        game_x.push_back('{1'b1, 1, 1, 18'h00285, 4'd4, 1'b0, 1'b0, 1'b0});
        game_x.push_back('{1'b0, 2, 0, 18'h00295, 4'd5, 1'b1, 1'b0, 1'b0});
        // Draw: X O X / X O O / O X X.
        game_draw.push_back('{1'b0, 0, 0, 18'h00001, 4'd1, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b1, 1, 0, 18'h00009, 4'd2, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b0, 2, 0, 18'h00019, 4'd3, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b1, 1, 1, 18'h00219, 4'd4, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b0, 0, 1, 18'h00259, 4'd5, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b1, 2, 1, 18'h00A59, 4'd6, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b0, 1, 2, 18'h04A59, 4'd7, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b1, 0, 2, 18'h06A59, 4'd8, 1'b0, 1'b0, 1'b0});
        game_draw.push_back('{1'b0, 2, 2, 18'h16A59, 4'd9, 1'b0, 1'b0, 1'b1});
        // 9th move completes column 2 for X: X O X / O O X / O X X.
        game_late.push_back('{1'b0, 0, 0, 18'h00001, 4'd1, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b1, 1, 0, 18'h00009, 4'd2, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b0, 2, 0, 18'h00019, 4'd3, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b1, 0, 1, 18'h00099, 4'd4, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b0, 2, 1, 18'h00499, 4'd5, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b1, 1, 1, 18'h00699, 4'd6, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b0, 1, 2, 18'h04699, 4'd7, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b1, 0, 2, 18'h06699, 4'd8, 1'b0, 1'b0, 1'b0});
        game_late.push_back('{1'b0, 2, 2, 18'h16699, 4'd9, 1'b1, 1'b0, 1'b0});

        // Reset state.
        repeat (2) tick();
        check("reset cells", Cells, 18'h0);
        check("reset movecnt", MoveCnt, 4'd0);
        check("reset flags", {Xwins, Owins, Draw, MoveAck, Invalid}, 5'b0);
        check("reset cursor", {CurX, CurY}, {2'd1, 2'd1});
        Resetn = 1'b1;
        tick();

        // First move lands in the centre.
        play('{1'b0, 1, 1, 18'h00100, 4'd1, 1'b0, 1'b0, 1'b0}, "first move");
        check("first move centre code", Cells[9:8], 2'b01);

        // BtnC on occupied centre: Invalid pulse, no write, FSM stays in WAIT.
        MoveReq = 1'b1;
        tick();
        BtnC = 1'b1;
        tick();
        BtnC = 1'b0;
        check("invalid pulse", Invalid, 1'b1);
        tick();
        check("invalid one cycle", Invalid, 1'b0);
        check("invalid no ack", MoveAck, 1'b0);
        check("invalid cells", Cells, 18'h00100);
        BtnR = 1'b1;
        tick();
        BtnR = 1'b0;
        check("invalid still in wait", CurX, 2'd2);
        MoveReq = 1'b0;
        tick();

        // Cursor wrap, then drop MoveReq in WAIT (no write, no ack).
        do_clear();
        check("clear cells", Cells, 18'h0);
        check("clear cursor", {CurX, CurY}, {2'd1, 2'd1});
        MoveReq = 1'b1;
        tick();
        repeat (2) begin BtnR = 1'b1; tick(); BtnR = 1'b0; end
        repeat (2) begin BtnU = 1'b1; tick(); BtnU = 1'b0; end
        check("wrap R,R,U,U", {CurX, CurY}, {2'd0, 2'd2});
        BtnL = 1'b1; tick(); BtnL = 1'b0;
        BtnD = 1'b1; tick(); BtnD = 1'b0;
        check("wrap L,D", {CurX, CurY}, {2'd2, 2'd0});
        MoveReq = 1'b0;
        tick();
        check("abort in wait cells", Cells, 18'h0);
        check("abort in wait cnt", MoveCnt, 4'd0);
        check("abort in wait no ack", MoveAck, 1'b0);
        cx = 2;
        cy = 0;

        // X wins, then a further request is ignored.
        for (int i = 0; i < game_x.size(); i++) play(game_x[i], $sformatf("xwin m%0d", i + 1));
        MoveReq = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            BtnC = k[0];
            BtnU = ~k[0];
            tick();
            if (MoveAck) acks++;
        end
        BtnC = 1'b0;
        BtnU = 1'b0;
        MoveReq = 1'b0;
        check("after win no ack", acks, 0);
        check("after win cells", Cells, 18'h00295);
        check("after win cursor", {CurX, CurY}, {2'd2, 2'd0});
        tick();

        // Draw game.
        do_clear();
        for (int i = 0; i < game_draw.size(); i++) play(game_draw[i], $sformatf("draw m%0d", i + 1));
        check("draw final cnt", MoveCnt, 4'd9);

        // Win on the 9th move beats Draw.
        do_clear();
        for (int i = 0; i < game_late.size(); i++) play(game_late[i], $sformatf("late m%0d", i + 1));

        // BtnC and BtnU together: commit at the original position.
        do_clear();
        MoveReq = 1'b1;
        Player  = 1'b1;
        tick();
        BtnC = 1'b1;
        BtnU = 1'b1;
        acks = 0;
        for (int k = 0; k < 8 && acks == 0; k++) begin
            tick();
            BtnC = 1'b0;
            BtnU = 1'b0;
            if (MoveAck) acks++;
        end
        check("C+U acked", acks, 1);
        check("C+U cells", Cells, 18'h00200);
        check("C+U cursor", {CurX, CurY}, {2'd1, 2'd1});
        MoveReq = 1'b0;
        repeat (2) tick();

        // Clear asserted in EVAL.
        MoveReq = 1'b1;
        Player  = 1'b0;
        tick();
        BtnR = 1'b1; tick(); BtnR = 1'b0;
        BtnC = 1'b1;
        tick();                 // COMMIT
        BtnC = 1'b0;
        tick();                 // EVAL
        Clear   = 1'b1;
        MoveReq = 1'b0;
        tick();
        Clear = 1'b0;
        acks = 0;
        if (MoveAck) acks++;
        check("clear in eval cells", Cells, 18'h0);
        check("clear in eval cnt", MoveCnt, 4'd0);
        check("clear in eval cursor", {CurX, CurY}, {2'd1, 2'd1});
        repeat (3) begin tick(); if (MoveAck) acks++; end
        check("clear in eval no ack", acks, 0);
        cx = 1;
        cy = 1;
        play('{1'b0, 1, 1, 18'h00100, 4'd1, 1'b0, 1'b0, 1'b0}, "after clear");

        // Resetn pulsed while in COMMIT.
        MoveReq = 1'b1;
        Player  = 1'b1;
        tick();
        BtnL = 1'b1; tick(); BtnL = 1'b0;
        BtnC = 1'b1;
        tick();                 // COMMIT
        BtnC = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        check("reset mid-move cells", Cells, 18'h0);
        check("reset mid-move cnt", MoveCnt, 4'd0);
        check("reset mid-move flags", {Xwins, Owins, Draw, MoveAck, Invalid}, 5'b0);
        check("reset mid-move cursor", {CurX, CurY}, {2'd1, 2'd1});
        MoveReq = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        check("after reset no write", Cells, 18'h0);
        cx = 1;
        cy = 1;
        play('{1'b1, 0, 0, 18'h00002, 4'd1, 1'b0, 1'b0, 1'b0}, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
